ram_port_arb: RTL and testbench
===============================

RAM_PORT_ARB -- requirements
Module: ram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM word-address width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have, per requester i in {0,1}, port mi_req  input  1  access request, held until accepted.
REQ-005 SHALL have mi_wr  input  1  1=write, 0=read.
REQ-006 SHALL have mi_wstrb  input  4  byte write strobes; ignored on reads.
REQ-007 SHALL have mi_addr  input  ADDR_W  word address.
REQ-008 SHALL have mi_wdata  input  32  write data.
REQ-009 SHALL have mi_addr_ok  output  1  request accepted this cycle.
REQ-010 SHALL have mi_data_ok  output  1  response for mi's accepted access.
REQ-011 SHALL have mi_rdata  output  32  read data, valid with mi_data_ok on reads.
REQ-012 SHALL have rr_en  input  1  1=round-robin, 0=fixed priority m1 over m0.
REQ-013 SHALL have ram_en, ram_wen[3:0], ram_addr[ADDR_W-1:0], ram_wdata[31:0] outputs and ram_rdata[31:0] input to the single-port synchronous RAM (1-cycle registered inputs, read data valid the cycle after access, byte writes committed one edge later).

Function
REQ-014 SHALL grant at most one requester per cycle; grant is combinational from current mi_req, rr_en and the priority pointer.
REQ-015 SHALL, for a granted requester, assert mi_addr_ok, ram_en=1, ram_addr=mi_addr, ram_wdata=mi_wdata, ram_wen=mi_wr ? mi_wstrb : 4'b0 in the same cycle.
REQ-016 SHALL drive ram_en=0, ram_wen=0 when no requester is granted; ram_addr/ram_wdata are don't-care then.
REQ-017 SHALL, with rr_en=1, keep 1-bit register last_gnt; when both request, grant ~last_gnt; update last_gnt to the granted index on every grant.
REQ-018 SHALL, with rr_en=0, grant m1 whenever m1_req=1, else m0; last_gnt still updates.
REQ-019 SHALL track the response with registers resp_vld and resp_id: on a grant in cycle k, resp_vld=1 and resp_id=granted index in cycle k+1; with no grant, resp_vld=0 in cycle k+1.
REQ-020 SHALL assert mi_data_ok = resp_vld && resp_id==i, exactly one cycle, cycle k+1, for both reads and writes.
REQ-021 SHALL drive mi_rdata = ram_rdata for both requesters (data meaningful only with mi_data_ok on a read).
REQ-022 SHALL sustain one access per cycle: a new grant in cycle k+1 is allowed while the response of cycle k is returned.
REQ-023 SHALL preserve program order per address: write granted in cycle k followed by read granted in cycle k+1 to same address returns the new data in cycle k+2; no stall inserted.
REQ-024 SHALL ignore strobes with mi_wr=1 and mi_wstrb=0 but still grant and return data_ok (no-op write).
REQ-025 SHALL not drop a pending request: a non-granted requester keeps mi_req high and is granted no later than the second following cycle in round-robin mode.
REQ-026 SHALL allow rr_en to change any cycle, effective on the same cycle's grant.

Reset
REQ-027 SHALL, while resetn=0, force last_gnt=1 (so m0 wins first round-robin tie), resp_vld=0, resp_id=0.
REQ-028 SHALL, while resetn=0, force mi_addr_ok=0, mi_data_ok=0, ram_en=0, ram_wen=0 combinationally, regardless of mi_req.
REQ-029 SHALL discard any in-flight response when reset asserts mid-access (no data_ok after reset release for pre-reset grants).
REQ-030 SHALL accept requests from the first rising edge after resetn deasserts.

Verification
REQ-031 SHALL pass: single m0 write addr 0x005, wdata 0xA5A5_1234, wstrb 4'b1111, then m0 read 0x005 -> m0_addr_ok each request cycle, m0_data_ok one cycle later, rdata 0xA5A5_1234.
REQ-032 SHALL pass: byte write 0x005 wstrb 4'b0010 wdata 0x0000_FF00 over 0xA5A5_1234, read back -> 0xA5A5_FF34.
REQ-033 SHALL pass: rr_en=1, m0_req and m1_req held high 6 cycles after reset -> grants m0,m1,m0,m1,m0,m1; data_ok for each one cycle after its addr_ok, never both in one cycle.
REQ-034 SHALL pass: rr_en=0, both requesting 4 cycles -> m1 granted all 4, m0_addr_ok=0 throughout; m0 granted the cycle m1_req drops.
REQ-035 SHALL pass: m1 write 0x3FF 0xDEAD_BEEF in cycle k, m0 read 0x3FF in cycle k+1 -> m0_data_ok in k+2 with rdata 0xDEAD_BEEF.
REQ-036 SHALL pass: resetn pulsed low in the cycle after a grant -> no data_ok during or after reset; ram_en=0 while low; m0 wins first tie after release.

Source files
------------

// File: rtl/ram_port_arb_if.sv
// Requester-side bundle for one port of ram_port_arb: request/command fields
// driven by the requester, accept/response fields driven by the arbiter.
// Latency and flow control are defined by the arbiter; this only groups the wires.
//
// Ports (per instance):
//   req/wr/wstrb/addr/wdata : request and command, held by requester until addr_ok
//   addr_ok                 : request accepted this cycle
//   data_ok/rdata           : response one cycle after acceptance (rdata on reads)
interface ram_port_arb_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              wr;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/ram_port_arb.sv
// Two-requester arbiter onto one single-port synchronous RAM (byte-write capable).
// Latency: grant/addr_ok combinational in the request cycle, data_ok the next cycle.
// Backpressure: a losing requester holds req; round-robin serves it within two cycles.
//
// Ports:
//   clk, resetn     : single clock, asynchronous active-low reset
//   rr_en           : 1 = round-robin, 0 = fixed priority (m1 over m0)
//   m0, m1          : requester ports (ram_port_arb_if.slave)
//   ram_en/ram_wen/ram_addr/ram_wdata/ram_rdata : RAM access port
module ram_port_arb #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rr_en,
    ram_port_arb_if.slave     m0,
    ram_port_arb_if.slave     m1,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic gnt0;
    logic gnt1;
    logic last_gnt;   // index of the most recently granted requester
    logic resp_vld;   // a grant happened last cycle
    logic resp_id;    // which requester that grant belonged to

    // Grant is purely combinational; resetn gates it so nothing is accepted
    // or driven to the RAM while reset is held, whatever the requests say.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (resetn) begin
            if (rr_en) begin
                // On a tie, the requester not served last time wins.
                gnt1 = m1.req && (!m0.req || !last_gnt);
            end else begin
                gnt1 = m1.req;
            end
            gnt0 = m0.req && !gnt1;
        end
    end

    // RAM command mux. Address/data follow m0 when idle; they are ignored
    // by the RAM because ram_en is low.
    always_comb begin
        ram_en    = gnt0 || gnt1;
        ram_wen   = 4'b0000;
        ram_addr  = m0.addr;
        ram_wdata = m0.wdata;
        if (gnt1) begin
            ram_addr  = m1.addr;
            ram_wdata = m1.wdata;
            ram_wen   = m1.wr ? m1.wstrb : 4'b0000;
        end else if (gnt0) begin
            ram_wen   = m0.wr ? m0.wstrb : 4'b0000;
        end
    end

    // Response tracking. Because the RAM returns read data exactly one cycle
    // after the access and commits writes at the same edge, a write followed
    // by a read to the same address on back-to-back cycles needs no stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt <= 1'b1;   // m0 wins the first round-robin tie
            resp_vld <= 1'b0;
            resp_id  <= 1'b0;
        end else begin
            resp_vld <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                last_gnt <= gnt1;
                resp_id  <= gnt1;
            end
        end
    end

    assign m0.addr_ok = gnt0;
    assign m1.addr_ok = gnt1;

    // resetn gating also hides a response whose grant preceded the reset.
    assign m0.data_ok = resetn && resp_vld && !resp_id;
    assign m1.data_ok = resetn && resp_vld &&  resp_id;

    assign m0.rdata = ram_rdata;
    assign m1.rdata = ram_rdata;

endmodule

// File: tb/tb_ram_port_arb.sv
module tb_ram_port_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rr_en;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    ram_port_arb_if #(.ADDR_W(10)) m0_if ();
    ram_port_arb_if #(.ADDR_W(10)) m1_if ();

    ram_port_arb #(.ADDR_W(10)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rr_en    (rr_en),
        .m0       (m0_if.slave),
        .m1       (m1_if.slave),
        .ram_en   (ram_en),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: registered access, byte writes, read data next cycle.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_wen == 4'b0000) ram_rdata <= mem[ram_addr];
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic        rr;
        logic        r0; logic w0; logic [3:0] s0; logic [9:0] ad0; logic [31:0] wd0;
        logic        r1; logic w1; logic [3:0] s1; logic [9:0] ad1; logic [31:0] wd1;
        logic        ea0; logic ea1; logic ed0; logic ed1; logic een;
        logic [3:0]  ewen;
        logic [9:0]  eaddr;
        logic        crd;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input vec_t v);
        rr_en       = v.rr;
        m0_if.req   = v.r0; m0_if.wr = v.w0; m0_if.wstrb = v.s0;
        m0_if.addr  = v.ad0; m0_if.wdata = v.wd0;
        m1_if.req   = v.r1; m1_if.wr = v.w1; m1_if.wstrb = v.s1;
        m1_if.addr  = v.ad1; m1_if.wdata = v.wd1;
    endtask

    task automatic set_req(input logic r0, input logic r1);
        m0_if.req = r0; m0_if.wr = 1'b0; m0_if.wstrb = 4'h0; m0_if.addr = 10'h005; m0_if.wdata = 32'h0;
        m1_if.req = r1; m1_if.wr = 1'b0; m1_if.wstrb = 4'h0; m1_if.addr = 10'h3FF; m1_if.wdata = 32'h0;
    endtask

    task automatic chk_outs(input string nm, input logic a0, input logic a1,
                            input logic d0, input logic d1, input logic en);
        chk({nm, " m0_addr_ok"}, {31'b0, m0_if.addr_ok}, {31'b0, a0});
        chk({nm, " m1_addr_ok"}, {31'b0, m1_if.addr_ok}, {31'b0, a1});
        chk({nm, " m0_data_ok"}, {31'b0, m0_if.data_ok}, {31'b0, d0});
        chk({nm, " m1_data_ok"}, {31'b0, m1_if.data_ok}, {31'b0, d1});
        chk({nm, " ram_en"},     {31'b0, ram_en},        {31'b0, en});
    endtask

    initial begin
        // rr  r0 w0 s0    ad0     wd0           r1 w1 s1    ad1     wd1           a0 a1 d0 d1 en wen   eaddr   crd erd
        vecs.push_back('{1'b1, 1,1,4'hF,10'h005,32'hA5A51234, 0,0,4'h0,10'h000,32'h0, 1,0,0,0,1,4'hF,10'h005,0,32'h0});
        vecs.push_back('{1'b1, 1,0,4'h0,10'h005,32'h0,        0,0,4'h0,10'h000,32'h0, 1,0,1,0,1,4'h0,10'h005,0,32'h0});
        vecs.push_back('{1'b1, 0,0,4'h0,10'h000,32'h0,        0,0,4'h0,10'h000,32'h0, 0,0,1,0,0,4'h0,10'h000,1,32'hA5A51234});
        vecs.push_back('{1'b1, 1,1,4'h2,10'h005,32'h0000FF00, 0,0,4'h0,10'h000,32'h0, 1,0,0,0,1,4'h2,10'h005,0,32'h0});
        vecs.push_back('{1'b1, 1,0,4'h0,10'h005,32'h0,        0,0,4'h0,10'h000,32'h0, 1,0,1,0,1,4'h0,10'h005,0,32'h0});
        vecs.push_back('{1'b1, 0,0,4'h0,10'h000,32'h0,        0,0,4'h0,10'h000,32'h0, 0,0,1,0,0,4'h0,10'h000,1,32'hA5A5FF34});
        vecs.push_back('{1'b1, 0,0,4'h0,10'h000,32'h0,        1,1,4'hF,10'h3FF,32'hDEADBEEF, 0,1,0,0,1,4'hF,10'h3FF,0,32'h0});
        vecs.push_back('{1'b1, 1,0,4'h0,10'h3FF,32'h0,        0,0,4'h0,10'h000,32'h0, 1,0,0,1,1,4'h0,10'h3FF,0,32'h0});
        vecs.push_back('{1'b1, 0,0,4'h0,10'h000,32'h0,        0,0,4'h0,10'h000,32'h0, 0,0,1,0,0,4'h0,10'h000,1,32'hDEADBEEF});
        vecs.push_back('{1'b1, 1,1,4'h0,10'h005,32'hFFFFFFFF, 0,0,4'h0,10'h000,32'h0, 1,0,0,0,1,4'h0,10'h005,0,32'h0});
        vecs.push_back('{1'b1, 1,0,4'h0,10'h005,32'h0,        0,0,4'h0,10'h000,32'h0, 1,0,1,0,1,4'h0,10'h005,0,32'h0});
        vecs.push_back('{1'b1, 0,0,4'h0,10'h000,32'h0,        0,0,4'h0,10'h000,32'h0, 0,0,1,0,0,4'h0,10'h000,1,32'hA5A5FF34});
        vecs.push_back('{1'b0, 1,0,4'h0,10'h005,32'h0,        1,0,4'h0,10'h3FF,32'h0, 0,1,0,0,1,4'h0,10'h3FF,0,32'h0});
        vecs.push_back('{1'b0, 1,0,4'h0,10'h005,32'h0,        1,0,4'h0,10'h3FF,32'h0, 0,1,0,1,1,4'h0,10'h3FF,1,32'hDEADBEEF});
        vecs.push_back('{1'b0, 1,0,4'h0,10'h005,32'h0,        1,0,4'h0,10'h3FF,32'h0, 0,1,0,1,1,4'h0,10'h3FF,0,32'h0});
        vecs.push_back('{1'b0, 1,0,4'h0,10'h005,32'h0,        1,0,4'h0,10'h3FF,32'h0, 0,1,0,1,1,4'h0,10'h3FF,0,32'h0});
        vecs.push_back('{1'b0, 1,0,4'h0,10'h005,32'h0,        0,0,4'h0,10'h000,32'h0, 1,0,0,1,1,4'h0,10'h005,0,32'h0});
        vecs.push_back('{1'b0, 0,0,4'h0,10'h000,32'h0,        0,0,4'h0,10'h000,32'h0, 0,0,1,0,0,4'h0,10'h000,1,32'hA5A5FF34});
        vecs.push_back('{1'b1, 1,0,4'h0,10'h005,32'h0,        1,0,4'h0,10'h3FF,32'h0, 0,1,0,0,1,4'h0,10'h3FF,0,32'h0});
        vecs.push_back('{1'b0, 1,0,4'h0,10'h005,32'h0,        1,0,4'h0,10'h3FF,32'h0, 0,1,0,1,1,4'h0,10'h3FF,0,32'h0});
        vecs.push_back('{1'b1, 1,0,4'h0,10'h005,32'h0,        1,0,4'h0,10'h3FF,32'h0, 1,0,0,1,1,4'h0,10'h005,0,32'h0});
        vecs.push_back('{1'b1, 0,0,4'h0,10'h000,32'h0,        0,0,4'h0,10'h000,32'h0, 0,0,1,0,0,4'h0,10'h000,1,32'hA5A5FF34});

        // Reset held with both requesting: nothing may be accepted or driven.
        resetn = 1'b0;
        rr_en  = 1'b1;
        set_req(1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outs("reset", 0, 0, 0, 0, 0);
        chk("reset ram_wen", {28'b0, ram_wen}, 32'h0);

        // Table-driven directed vectors, one per cycle.
        @(posedge clk); #1;
        resetn = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk_outs($sformatf("v%0d", i), vecs[i].ea0, vecs[i].ea1,
                     vecs[i].ed0, vecs[i].ed1, vecs[i].een);
            chk($sformatf("v%0d ram_wen", i), {28'b0, ram_wen}, {28'b0, vecs[i].ewen});
            if (vecs[i].een)
                chk($sformatf("v%0d ram_addr", i), {22'b0, ram_addr}, {22'b0, vecs[i].eaddr});
            if (vecs[i].crd) begin
                chk($sformatf("v%0d m0_rdata", i), m0_if.rdata, vecs[i].erd);
                chk($sformatf("v%0d m1_rdata", i), m1_if.rdata, vecs[i].erd);
            end
            @(posedge clk); #1;
        end

        // Round-robin from reset: both held high for six cycles.
        resetn = 1'b0;
        rr_en  = 1'b1;
        set_req(1'b1, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk_outs($sformatf("rr c%0d", c), (c % 2) == 0, (c % 2) == 1,
                     (c > 0) && ((c % 2) == 1), (c > 0) && ((c % 2) == 0), 1'b1);
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b0);
        @(negedge clk);
        chk_outs("rr tail", 0, 0, 0, 1, 0);
        @(posedge clk); #1;

        // Reset pulsed the cycle after a grant: the pending response is lost,
        // and the first tie afterwards goes to m0 even though m0 was last served.
        set_req(1'b1, 1'b0);
        @(negedge clk);
        chk_outs("rst k", 1, 0, 0, 0, 1);
        @(posedge clk); #1;
        resetn = 1'b0;
        set_req(1'b1, 1'b1);
        @(negedge clk);
        chk_outs("rst low0", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_outs("rst low1", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk_outs("rst rel0", 1, 0, 0, 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_outs("rst rel1", 0, 1, 1, 0, 1);
        chk("rst rel1 rdata", m0_if.rdata, 32'hA5A5FF34);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0);
        @(negedge clk);
        chk_outs("rst rel2", 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
